// File: rtl/vga_timing_pkg.sv
// Purpose: default 640x480@60 timing constants, derived totals and a small
//          range-decode helper shared by the VGA sync generator.
// Ports:   none (package).
package vga_timing_pkg;

  localparam int unsigned CNT_W     = 10;

  localparam int unsigned DEF_DIV    = 4;
  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  // 800 and 525 with the defaults above
  localparam int unsigned DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // True when lo <= val < hi
  function automatic logic in_range(logic [CNT_W-1:0] val,
                                    logic [CNT_W-1:0] lo,
                                    logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Purpose: bundle of raster position and timing strobes from the sync generator.
// Ports:   master drives h/v counters, hsync_n, vsync_n, video_on, pix_tick,
//          line_start, frame_start; slave observes them.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] h_counter;
  logic [CNT_W-1:0] v_counter;
  logic             hsync_n;
  logic             vsync_n;
  logic             video_on;
  logic             pix_tick;
  logic             line_start;
  logic             frame_start;

  modport master (
    output h_counter, v_counter, hsync_n, vsync_n, video_on,
           pix_tick, line_start, frame_start
  );

  modport slave (
    input  h_counter, v_counter, hsync_n, vsync_n, video_on,
           pix_tick, line_start, frame_start
  );

endinterface

// File: rtl/pix_tick_gen.sv
// Purpose: clock divider producing a registered one-clk pixel strobe every DIV clks.
// Ports:   clk, clear_n (async active-low reset), pix_tick (registered strobe).
module pix_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic clear_n,
  output logic pix_tick
);

  localparam int unsigned    DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Divider next value: 0..DIV-1 then wrap
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == LAST) begin
      div_d = '0;
    end
  end

  // Strobe is decoded from the next divider value so it lines up with div_q == LAST
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      div_q    <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_tick <= (div_d == LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: free-running VGA raster counters with registered sync/blank decode
//          and line/frame start strobes.
// Ports:   clk, clear_n (async active-low reset), vga (master modport carrying
//          h_counter, v_counter, hsync_n, vsync_n, video_on, pix_tick,
//          line_start, frame_start).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV    = DEF_DIV,
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP
) (
  input  logic           clk,
  input  logic           clear_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C   = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C   = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic             pix_tick;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;
  logic [CNT_W-1:0] h_d;
  logic [CNT_W-1:0] v_d;
  logic             line_wrap_c;
  logic             frame_wrap_c;
  logic             hsync_n_q;
  logic             vsync_n_q;
  logic             video_on_q;
  logic             line_start_q;
  logic             frame_start_q;

  pix_tick_gen #(
    .DIV (DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .clear_n  (clear_n),
    .pix_tick (pix_tick)
  );

  // Next raster position; advances only on pixel strobes
  always_comb begin
    h_d          = h_q;
    v_d          = v_q;
    line_wrap_c  = 1'b0;
    frame_wrap_c = 1'b0;
    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d         = '0;
        line_wrap_c = 1'b1;
        if (v_q == V_LAST) begin
          v_d          = '0;
          frame_wrap_c = 1'b1;
        end else begin
          v_d = v_q + CNT_W'(1);
        end
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  // Counters plus decode of the next position, so sync/blank align with the counters
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_n_q     <= ~in_range(h_d, H_SYNC_LO, H_SYNC_HI);
      vsync_n_q     <= ~in_range(v_d, V_SYNC_LO, V_SYNC_HI);
      video_on_q    <= (h_d < H_VIS_C) && (v_d < V_VIS_C);
      line_start_q  <= line_wrap_c;
      frame_start_q <= frame_wrap_c;
    end
  end

  assign vga.h_counter   = h_q;
  assign vga.v_counter   = v_q;
  assign vga.hsync_n     = hsync_n_q;
  assign vga.vsync_n     = vsync_n_q;
  assign vga.video_on    = video_on_q;
  assign vga.pix_tick    = pix_tick;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: self-checking bench for vga_sync_gen; three instances (default 640x480,
//          a tiny DIV=1 raster and a DIV=3 raster) checked against an arithmetic
//          model that derives the raster position from clk edges since release.
// Ports:   none (top-level bench).
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  // Configs: 0 = defaults, 1 = tiny DIV=1, 2 = DIV=3 medium
  localparam int unsigned C_DIV   [3] = '{4, 1, 3};
  localparam int unsigned C_HVIS  [3] = '{640, 8, 10};
  localparam int unsigned C_HFP   [3] = '{16, 2, 3};
  localparam int unsigned C_HSYNC [3] = '{96, 2, 4};
  localparam int unsigned C_HBP   [3] = '{48, 2, 5};
  localparam int unsigned C_VVIS  [3] = '{480, 4, 6};
  localparam int unsigned C_VFP   [3] = '{10, 1, 2};
  localparam int unsigned C_VSYNC [3] = '{2, 1, 2};
  localparam int unsigned C_VBP   [3] = '{33, 1, 3};

  logic       clk = 1'b0;
  logic [2:0] clr = 3'b000;
  int unsigned n [3];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if if_d ();
  vga_sync_gen_if if_s ();
  vga_sync_gen_if if_m ();

  vga_sync_gen dut_d (
    .clk     (clk),
    .clear_n (clr[0]),
    .vga     (if_d)
  );

  vga_sync_gen #(
    .DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .clk     (clk),
    .clear_n (clr[1]),
    .vga     (if_s)
  );

  vga_sync_gen #(
    .DIV(3), .H_VIS(10), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_m (
    .clk     (clk),
    .clear_n (clr[2]),
    .vga     (if_m)
  );

  // Clk edges seen since the latest reset release, per instance
  always @(posedge clk or negedge clr[0]) if (!clr[0]) n[0] <= 0; else n[0] <= n[0] + 1;
  always @(posedge clk or negedge clr[1]) if (!clr[1]) n[1] <= 0; else n[1] <= n[1] + 1;
  always @(posedge clk or negedge clr[2]) if (!clr[2]) n[2] <= 0; else n[2] <= n[2] + 1;

  logic [25:0] obs_d, obs_s, obs_m;
  assign obs_d = {if_d.h_counter, if_d.v_counter, if_d.hsync_n, if_d.vsync_n,
                  if_d.video_on, if_d.pix_tick, if_d.line_start, if_d.frame_start};
  assign obs_s = {if_s.h_counter, if_s.v_counter, if_s.hsync_n, if_s.vsync_n,
                  if_s.video_on, if_s.pix_tick, if_s.line_start, if_s.frame_start};
  assign obs_m = {if_m.h_counter, if_m.v_counter, if_m.hsync_n, if_m.vsync_n,
                  if_m.video_on, if_m.pix_tick, if_m.line_start, if_m.frame_start};

  function automatic logic [25:0] get_obs(int c);
    case (c)
      0:       return obs_d;
      1:       return obs_s;
      default: return obs_m;
    endcase
  endfunction

  // Pixels completed after k edges: strobe is high in cycles k = DIV-1 (mod DIV), k >= 1,
  // and the pixel advances on the following edge.
  function automatic int unsigned pix_of(int c, int unsigned k);
    if (C_DIV[c] == 1) return (k == 0) ? 0 : k - 1;
    return k / C_DIV[c];
  endfunction

  function automatic logic [25:0] model(int c, int unsigned k);
    int unsigned p, h, v, htot, vtot, hs_lo, vs_lo;
    logic hs, vs, vo, pt, ls, fs;
    htot  = C_HVIS[c] + C_HFP[c] + C_HSYNC[c] + C_HBP[c];
    vtot  = C_VVIS[c] + C_VFP[c] + C_VSYNC[c] + C_VBP[c];
    p     = pix_of(c, k);
    h     = p % htot;
    v     = (p / htot) % vtot;
    hs_lo = C_HVIS[c] + C_HFP[c];
    vs_lo = C_VVIS[c] + C_VFP[c];
    hs    = !(h >= hs_lo && h < hs_lo + C_HSYNC[c]);
    vs    = !(v >= vs_lo && v < vs_lo + C_VSYNC[c]);
    vo    = (h < C_HVIS[c]) && (v < C_VVIS[c]);
    pt    = (k >= 1) && ((k % C_DIV[c]) == C_DIV[c] - 1);
    ls    = (k >= 1) && (p != pix_of(c, k - 1)) && (h == 0);
    fs    = ls && (v == 0);
    return {10'(h), 10'(v), hs, vs, vo, pt, ls, fs};
  endfunction

  task automatic test_reset();
    logic [25:0] exp_rst;
    exp_rst = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    clr = 3'b000;
    repeat (5) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        vectors++;
        if (get_obs(c) !== exp_rst) begin
          miscompares++;
          $display("FAIL reset_hold[%0d] got=%h exp=%h", c, get_obs(c), exp_rst);
        end
      end
    end
  endtask

  task automatic test_first_tick();
    logic exp_pt;
    logic [9:0] exp_h;
    @(negedge clk);
    clr = 3'b111;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_pt = (k == 3) || (k == 7) || (k == 11);
      exp_h  = 10'((k >= 4 ? 1 : 0) + (k >= 8 ? 1 : 0) + (k >= 12 ? 1 : 0));
      vectors++;
      if (if_d.pix_tick !== exp_pt || if_d.h_counter !== exp_h) begin
        miscompares++;
        $display("FAIL first_tick k=%0d got tick=%b h=%0d exp tick=%b h=%0d",
                 k, if_d.pix_tick, if_d.h_counter, exp_pt, exp_h);
      end
      for (int c = 0; c < 3; c++) begin
        vectors++;
        if (get_obs(c) !== model(c, n[c])) begin
          miscompares++;
          $display("FAIL startup[%0d] n=%0d got=%h exp=%h", c, n[c], get_obs(c), model(c, n[c]));
        end
      end
    end
  endtask

  task automatic test_horizontal_edges();
    logic [25:0] e;
    repeat (3200) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        vectors++;
        if (get_obs(c) !== model(c, n[c])) begin
          miscompares++;
          $display("FAIL h_run[%0d] n=%0d got=%h exp=%h", c, n[c], get_obs(c), model(c, n[c]));
        end
      end
      // Fixed landmarks of the default line: n edges map to pixel n/4
      case (n[0])
        2559, 2560, 2623, 2624, 3007, 3008, 3200, 3201: begin
          case (n[0])
            2559:    e = {10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            2560:    e = {10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            2623:    e = {10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            2624:    e = {10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            3007:    e = {10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            3008:    e = {10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            3200:    e = {10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            default: e = {10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
          endcase
          vectors++;
          if (obs_d !== e) begin
            miscompares++;
            $display("FAIL h_landmark n=%0d got=%h exp=%h", n[0], obs_d, e);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_full_frame_small();
    int fs_cnt, vs_low, last_fs;
    fs_cnt = 0; vs_low = 0; last_fs = 0;
    @(negedge clk);
    clr[1] = 1'b0;
    @(negedge clk);
    clr[1] = 1'b1;
    repeat (491) begin
      @(negedge clk);
      if (if_s.frame_start === 1'b1) begin
        if (fs_cnt > 0) begin
          vectors++;
          if (int'(n[1]) - last_fs != 98) begin
            miscompares++;
            $display("FAIL frame_period got=%0d exp=98", int'(n[1]) - last_fs);
          end
        end
        fs_cnt++;
        last_fs = int'(n[1]);
      end
      if (if_s.vsync_n === 1'b0) vs_low++;
      vectors++;
      if (obs_s !== model(1, n[1])) begin
        miscompares++;
        $display("FAIL frame_run n=%0d got=%h exp=%h", n[1], obs_s, model(1, n[1]));
      end
    end
    vectors++;
    if (fs_cnt != 5) begin
      miscompares++;
      $display("FAIL frame_count got=%0d exp=5", fs_cnt);
    end
    vectors++;
    if (vs_low != 70) begin
      miscompares++;
      $display("FAIL vsync_low_clks got=%0d exp=70", vs_low);
    end
  endtask

  task automatic test_midframe_reset();
    int c;
    logic [25:0] exp_rst;
    exp_rst = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    repeat (8) begin
      c = int'($urandom_range(0, 2));
      repeat ($urandom_range(50, 900)) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          vectors++;
          if (get_obs(i) !== model(i, n[i])) begin
            miscompares++;
            $display("FAIL rand_run[%0d] n=%0d got=%h exp=%h", i, n[i], get_obs(i), model(i, n[i]));
          end
        end
      end
      // Assert between edges: outputs must clear with no clk edge
      @(posedge clk);
      #2;
      clr[c] = 1'b0;
      #1;
      vectors++;
      if (get_obs(c) !== exp_rst) begin
        miscompares++;
        $display("FAIL async_clear[%0d] got=%h exp=%h", c, get_obs(c), exp_rst);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      clr[c] = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_horizontal_edges();
    test_full_frame_small();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
